// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A pixel-clock divider produces
//   pix_ce, which advances a column counter (DrawX) and a line counter (DrawY).
//   Sync, blank and the line/frame strobes are registered from the next-state
//   counter values, so they line up with the DrawX/DrawY visible in the same
//   Clk cycle.
//
//   There is no valid/ready handshake on this block: pix_ce is the only
//   qualifier. A downstream pixel mapper consumes DrawX/DrawY on cycles where
//   pix_ce=1. All other outputs are level signals valid every cycle.
//
// Ports
//   Clk         in   system clock
//   Reset       in   synchronous, active-high reset
//   en          in   run enable; 0 freezes divider, counters and sync levels
//   hs          out  horizontal sync, HS_POL level inside the sync window
//   vs          out  vertical sync, VS_POL level inside the sync window
//   blank       out  1 in the active display region (DAC blank_n)
//   sync        out  composite sync, constant 0
//   DrawX       out  current column, 0..H_TOTAL-1
//   DrawY       out  current line, 0..V_TOTAL-1
//   pix_ce      out  one-Clk pulse on every pixel advance
//   line_start  out  one-Clk pulse in the first cycle DrawX shows 0 after a wrap
//   frame_start out  as line_start, but only when DrawY also wrapped to 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 11
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          pix_ce,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW1     = CW + 1;

  localparam logic [DW-1:0] DC_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit: a sync window may end exactly at
  // 2**CW when the back porch is zero and the total fills the counter.
  localparam logic [CW:0] X_ACT  = CW1'(H_ACTIVE);
  localparam logic [CW:0] Y_ACT  = CW1'(V_ACTIVE);
  localparam logic [CW:0] HS_BEG = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_BEG = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = CW1'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_TOTAL > 2**CW) || (V_TOTAL > 2**CW)) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Pixel clock divider. With CLK_DIV=1, DC_LAST is 0 and dc never leaves 0,
  // so pix_ce reduces to en.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dc;
  logic          dc_wrap;

  assign dc_wrap = (dc == DC_LAST);
  assign pix_ce  = en & dc_wrap;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      dc <= '0;
    end else if (en) begin
      dc <= dc_wrap ? '0 : dc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state counters. With pix_ce=0 the next state equals the current
  // state, so the registered decodes below hold their value while en=0.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] x_nx;
  logic [CW-1:0] y_nx;
  logic          ls_nx;
  logic          fs_nx;
  logic          hs_act;
  logic          vs_act;
  logic          blank_nx;

  always_comb begin
    x_nx  = DrawX;
    y_nx  = DrawY;
    ls_nx = 1'b0;
    fs_nx = 1'b0;
    if (pix_ce) begin
      if (DrawX == X_LAST) begin
        x_nx  = '0;
        ls_nx = 1'b1;
        if (DrawY == Y_LAST) begin
          y_nx  = '0;
          fs_nx = 1'b1;
        end else begin
          y_nx = DrawY + 1'b1;
        end
      end else begin
        x_nx = DrawX + 1'b1;
      end
    end
  end

  assign hs_act   = ({1'b0, x_nx} >= HS_BEG) && ({1'b0, x_nx} < HS_END);
  assign vs_act   = ({1'b0, y_nx} >= VS_BEG) && ({1'b0, y_nx} < VS_END);
  assign blank_nx = ({1'b0, x_nx} < X_ACT) && ({1'b0, y_nx} < Y_ACT);

  // ---------------------------------------------------------------------------
  // Registered position and decodes
  // ---------------------------------------------------------------------------
  logic ls_q;
  logic fs_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      DrawX <= '0;
      DrawY <= '0;
      hs    <= ~HS_POL;
      vs    <= ~VS_POL;
      blank <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      DrawX <= x_nx;
      DrawY <= y_nx;
      hs    <= hs_act ? HS_POL : ~HS_POL;
      vs    <= vs_act ? VS_POL : ~VS_POL;
      blank <= blank_nx;
      ls_q  <= ls_nx;
      fs_q  <= fs_nx;
    end
  end

  // Strobes are suppressed while frozen so a consumer never sees a start
  // pulse in a cycle where the raster is not running.
  assign line_start  = ls_q & en;
  assign frame_start = fs_q & en;
  assign sync        = 1'b0;

endmodule
